branch_feedback: RTL and testbench
==================================

BRANCH_FEEDBACK -- requirements
Module: branch_feedback

Interface
REQ-001 Parameter DEPTH, default 8, meaning the number of in-flight predicted branches tracked; SHALL be a power of two, at least 2.
REQ-002 Parameter DAT_W, default `DAT_W (32), meaning the PC and target width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; asynchronous and active-high.
REQ-005 en  in  1  global ready; when low, all state SHALL hold and no pushes or resolves are accepted.
REQ-006 if_push_i  in  1  IF issued a branch together with its prediction this cycle.
REQ-007 if_pc_i  in  DAT_W  PC of the pushed branch.
REQ-008 if_pbr_i  in  1  predicted taken.
REQ-009 if_full_o  out  1  queue full; IF SHALL stall branch issue while it is high.
REQ-010 cm_en_i  in  1  oldest branch resolved (in program order).
REQ-011 cm_abr_i  in  1  actual taken.
REQ-012 cm_tgt_i  in  DAT_W  actual taken target.
REQ-013 bp_en_o  out  1  predictor update strobe.
REQ-014 bp_abr_o  out  1  actual taken outcome to the predictor.
REQ-015 bp_tpc_o  out  DAT_W  PC of the resolved branch.
REQ-016 mp_o  out  1  mispredict/redirect pulse.
REQ-017 mp_pc_o  out  DAT_W  redirect PC.
REQ-018 cnt_o  out  $clog2(DEPTH)+1  current occupancy.
REQ-019 err_o  out  1  sticky flag: resolve arrived with an empty queue.
REQ-020 mp_cnt_o  out  16  saturating count of mispredicts.

Function
REQ-021 Push: when en && if_push_i && !full, the block SHALL write {pc, pbr} at the tail and increment the tail; a push while full SHALL be dropped with state unchanged.
REQ-022 Resolve: when en && cm_en_i && !empty, the block SHALL pop the head entry, compare its pbr with cm_abr_i, and register the outputs, so that they are valid exactly 1 cycle later.
REQ-023 On a resolve, bp_en_o=1, bp_abr_o=cm_abr_i and bp_tpc_o=head pc SHALL be asserted for 1 cycle.
REQ-024 When pbr != cm_abr_i, mp_o=1 SHALL be asserted for 1 cycle: mp_pc_o = cm_tgt_i if taken, otherwise head pc + 4 (mod 2^DAT_W).
REQ-025 On a mispredict, all remaining entries are wrong-path: head, tail and count SHALL be cleared in the same edge, and a push in the same cycle SHALL be dropped.
REQ-026 Simultaneous push and correct resolve SHALL be allowed even when full, since the pop frees the slot; the count is unchanged.
REQ-027 Pointers SHALL wrap modulo DEPTH; full = (cnt == DEPTH), empty = (cnt == 0), and if_full_o is combinational from cnt.
REQ-028 A resolve while empty SHALL produce no bp_en_o or mp_o and SHALL set err_o, which holds until reset.
REQ-029 mp_cnt_o SHALL increment on each mispredict and saturate at 16'hFFFF.
REQ-030 When en is low, bp_en_o and mp_o SHALL be 0 on the next edge; all other registers SHALL hold.

Reset
REQ-031 Asserting rst SHALL at any time, including mid-operation, immediately clear pointers, cnt_o, bp_en_o, bp_abr_o, bp_tpc_o, mp_o, mp_pc_o, err_o and mp_cnt_o to 0; entry storage need not be cleared.
REQ-032 After rst deasserts, the first push SHALL be accepted on the first rising edge with en high.

Structure
REQ-033 DAT_W and the shared defines come from head.v, protected by an include guard; DEPTH stays a local parameter.
REQ-034 The storage, pointers and count SHALL live in one sub-module, bf_queue, which provides push, pop and clear; compare, redirect and the counters stay in the top module.

Verification
REQ-035 Push pc=0x100 with pbr=1, then resolve with abr=1 and tgt=0x200 -> next cycle bp_en_o=1, bp_tpc_o=0x100, bp_abr_o=1, mp_o=0, and cnt_o goes 1 then 0.
REQ-036 Push pc=0x104 with pbr=1, then resolve with abr=0 -> mp_o=1 with mp_pc_o=0x108, and mp_cnt_o=1.
REQ-037 Push 8 entries -> if_full_o=1 and a 9th push is dropped; a simultaneous push and correct resolve keeps cnt_o=8, and the pushed entry is popped 8 resolves later in FIFO order.
REQ-038 Push 3 entries (pbr=0), then resolve the first with abr=1 and tgt=0x400 while pushing a 4th -> mp_pc_o=0x400, cnt_o=0, and the 4th entry is never resolved.
REQ-039 Resolve on an empty queue -> bp_en_o=0, mp_o=0, err_o=1 held until rst.
REQ-040 Assert rst asynchronously between edges with cnt_o=5 -> all outputs read 0 before the next edge.

Source files
------------

// File: rtl/branch_feedback_pkg.sv
// Shared defines and types for the branch feedback block: resolve classification
// and the counter width used by the mispredict statistics.
`ifndef HEAD_V
`define HEAD_V
`define DAT_W 32
`endif

package branch_feedback_pkg;

    localparam int unsigned MP_CNT_W = 16;

    typedef enum logic [1:0] {
        RES_IDLE,
        RES_HIT,
        RES_MISS,
        RES_EMPTY
    } res_e;

    function automatic res_e classify(input logic req, input logic empty,
                                      input logic pbr, input logic abr);
        if (!req)          return RES_IDLE;
        else if (empty)    return RES_EMPTY;
        else if (pbr != abr) return RES_MISS;
        else               return RES_HIT;
    endfunction

endpackage

// File: rtl/bf_queue.sv
// In-order queue of predicted branches {pc, pbr}; clear flushes pointers and count
// and takes priority over push/pop.
module bf_queue #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned DAT_W = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [DAT_W-1:0] pc_i,
    input  logic             pbr_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [DAT_W-1:0] head_pc_o,
    output logic             head_pbr_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [DAT_W-1:0] pc_mem [DEPTH];
    logic [DEPTH-1:0] pbr_mem;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_i) tail_d = tail_q + PTR_W'(1);
            if (pop_i)  head_d = head_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is intentionally not reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            pc_mem[tail_q]  <= pc_i;
            pbr_mem[tail_q] <= pbr_i;
        end
    end

    assign head_pc_o  = pc_mem[head_q];
    assign head_pbr_o = pbr_mem[head_q];
    assign cnt_o      = cnt_q;
    assign full_o     = (cnt_q == CNT_W'(DEPTH));
    assign empty_o    = (cnt_q == '0);

endmodule

// File: rtl/branch_feedback.sv
// Branch resolution feedback: compares the oldest prediction with the committed
// outcome, updates the predictor, and raises a redirect on mispredict.
`ifndef HEAD_V
`define HEAD_V
`define DAT_W 32
`endif

module branch_feedback
    import branch_feedback_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned DAT_W = `DAT_W,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                if_push_i,
    input  logic [DAT_W-1:0]    if_pc_i,
    input  logic                if_pbr_i,
    output logic                if_full_o,
    input  logic                cm_en_i,
    input  logic                cm_abr_i,
    input  logic [DAT_W-1:0]    cm_tgt_i,
    output logic                bp_en_o,
    output logic                bp_abr_o,
    output logic [DAT_W-1:0]    bp_tpc_o,
    output logic                mp_o,
    output logic [DAT_W-1:0]    mp_pc_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic                err_o,
    output logic [MP_CNT_W-1:0] mp_cnt_o
);

    res_e             res_kind;
    logic             q_push, q_pop, q_clear;
    logic             q_full, q_empty;
    logic [DAT_W-1:0] head_pc;
    logic             head_pbr;

    logic                bp_en_q, bp_en_d;
    logic                bp_abr_q, bp_abr_d;
    logic [DAT_W-1:0]    bp_tpc_q, bp_tpc_d;
    logic                mp_q, mp_d;
    logic [DAT_W-1:0]    mp_pc_q, mp_pc_d;
    logic                err_q, err_d;
    logic [MP_CNT_W-1:0] mp_cnt_q, mp_cnt_d;

    assign res_kind = en ? classify(cm_en_i, q_empty, head_pbr, cm_abr_i) : RES_IDLE;
    assign q_pop    = (res_kind == RES_HIT) || (res_kind == RES_MISS);
    assign q_clear  = (res_kind == RES_MISS);
    // A correct pop frees a slot this cycle, so a full queue may still accept.
    assign q_push   = en && if_push_i && (res_kind != RES_MISS)
                      && (!q_full || (res_kind == RES_HIT));

    bf_queue #(
        .DEPTH (DEPTH),
        .DAT_W (DAT_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_i     (q_push),
        .pc_i       (if_pc_i),
        .pbr_i      (if_pbr_i),
        .pop_i      (q_pop),
        .clear_i    (q_clear),
        .head_pc_o  (head_pc),
        .head_pbr_o (head_pbr),
        .cnt_o      (cnt_o),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    always_comb begin
        bp_en_d  = 1'b0;
        bp_abr_d = bp_abr_q;
        bp_tpc_d = bp_tpc_q;
        mp_d     = 1'b0;
        mp_pc_d  = mp_pc_q;
        err_d    = err_q;
        mp_cnt_d = mp_cnt_q;
        if (q_pop) begin
            bp_en_d  = 1'b1;
            bp_abr_d = cm_abr_i;
            bp_tpc_d = head_pc;
        end
        if (res_kind == RES_MISS) begin
            mp_d    = 1'b1;
            mp_pc_d = cm_abr_i ? cm_tgt_i : head_pc + DAT_W'(4);
            if (mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + MP_CNT_W'(1);
        end
        if (res_kind == RES_EMPTY) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_en_q  <= 1'b0;
            bp_abr_q <= 1'b0;
            bp_tpc_q <= '0;
            mp_q     <= 1'b0;
            mp_pc_q  <= '0;
            err_q    <= 1'b0;
            mp_cnt_q <= '0;
        end else begin
            bp_en_q  <= bp_en_d;
            bp_abr_q <= bp_abr_d;
            bp_tpc_q <= bp_tpc_d;
            mp_q     <= mp_d;
            mp_pc_q  <= mp_pc_d;
            err_q    <= err_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign if_full_o = q_full;
    assign bp_en_o   = bp_en_q;
    assign bp_abr_o  = bp_abr_q;
    assign bp_tpc_o  = bp_tpc_q;
    assign mp_o      = mp_q;
    assign mp_pc_o   = mp_pc_q;
    assign err_o     = err_q;
    assign mp_cnt_o  = mp_cnt_q;

endmodule

// File: tb/tb_branch_feedback.sv
// Self-checking bench for branch_feedback: directed vector table, hand sequences
// for full/flush/reset corners, and a randomized run against a queue model.
module tb_branch_feedback;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          if_push_i;
    logic [DW-1:0] if_pc_i;
    logic          if_pbr_i;
    logic          if_full_o;
    logic          cm_en_i;
    logic          cm_abr_i;
    logic [DW-1:0] cm_tgt_i;
    logic          bp_en_o;
    logic          bp_abr_o;
    logic [DW-1:0] bp_tpc_o;
    logic          mp_o;
    logic [DW-1:0] mp_pc_o;
    logic [CW-1:0] cnt_o;
    logic          err_o;
    logic [15:0]   mp_cnt_o;

    int total = 0;
    int bad   = 0;

    branch_feedback #(
        .DEPTH (DEPTH),
        .DAT_W (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .if_push_i (if_push_i),
        .if_pc_i   (if_pc_i),
        .if_pbr_i  (if_pbr_i),
        .if_full_o (if_full_o),
        .cm_en_i   (cm_en_i),
        .cm_abr_i  (cm_abr_i),
        .cm_tgt_i  (cm_tgt_i),
        .bp_en_o   (bp_en_o),
        .bp_abr_o  (bp_abr_o),
        .bp_tpc_o  (bp_tpc_o),
        .mp_o      (mp_o),
        .mp_pc_o   (mp_pc_o),
        .cnt_o     (cnt_o),
        .err_o     (err_o),
        .mp_cnt_o  (mp_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        en = 1'b1; if_push_i = 1'b0; if_pc_i = '0; if_pbr_i = 1'b0;
        cm_en_i = 1'b0; cm_abr_i = 1'b0; cm_tgt_i = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", 32'(cnt_o), 0);
        chk("rst_bp_en", 32'(bp_en_o), 0);
        chk("rst_mp_cnt", 32'(mp_cnt_o), 0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        push;
        logic [31:0] pc;
        logic        pbr;
        logic        res;
        logic        abr;
        logic [31:0] tgt;
        logic        e_bp_en;
        logic        e_abr;
        logic [31:0] e_tpc;
        logic        e_mp;
        logic [31:0] e_mppc;
        int          e_cnt;
        logic        e_err;
        int          e_mpcnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        pbr;
    } ent_t;

    vec_t vt[$];
    ent_t mq[$];

    initial begin
        // push, pc, pbr, res, abr, tgt | bp_en, abr, tpc, mp, mppc, cnt, err, mpcnt
        vt.push_back('{1, 32'h100, 1, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 0, 0});
        vt.push_back('{0, 32'h0,   0, 1, 1, 32'h200, 1, 1, 32'h100, 0, 32'h0,   0, 0, 0});
        vt.push_back('{1, 32'h104, 1, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 0, 0});
        vt.push_back('{0, 32'h0,   0, 1, 0, 32'h999, 1, 0, 32'h104, 1, 32'h108, 0, 0, 1});
        vt.push_back('{0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 1});
        vt.push_back('{1, 32'h10,  0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 0, 1});
        vt.push_back('{1, 32'h14,  0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   2, 0, 1});
        vt.push_back('{1, 32'h18,  0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   3, 0, 1});
        vt.push_back('{1, 32'h1C,  0, 1, 1, 32'h400, 1, 1, 32'h10,  1, 32'h400, 0, 0, 2});
        vt.push_back('{0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 2});
        vt.push_back('{0, 32'h0,   0, 1, 1, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 2});
        vt.push_back('{0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 1, 2});

        rst = 1'b1;
        idle_inputs();
        #12;
        do_reset();

        for (int i = 0; i < vt.size(); i++) begin
            if_push_i = vt[i].push; if_pc_i = vt[i].pc; if_pbr_i = vt[i].pbr;
            cm_en_i = vt[i].res; cm_abr_i = vt[i].abr; cm_tgt_i = vt[i].tgt;
            step();
            chk($sformatf("v%0d_bp_en", i), 32'(bp_en_o), 32'(vt[i].e_bp_en));
            chk($sformatf("v%0d_mp", i), 32'(mp_o), 32'(vt[i].e_mp));
            chk($sformatf("v%0d_cnt", i), 32'(cnt_o), 32'(vt[i].e_cnt));
            chk($sformatf("v%0d_err", i), 32'(err_o), 32'(vt[i].e_err));
            chk($sformatf("v%0d_mpcnt", i), 32'(mp_cnt_o), 32'(vt[i].e_mpcnt));
            if (vt[i].e_bp_en) begin
                chk($sformatf("v%0d_abr", i), 32'(bp_abr_o), 32'(vt[i].e_abr));
                chk($sformatf("v%0d_tpc", i), bp_tpc_o, vt[i].e_tpc);
            end
            if (vt[i].e_mp) chk($sformatf("v%0d_mppc", i), mp_pc_o, vt[i].e_mppc);
        end
        idle_inputs();

        // Fill, overflow drop, push-with-correct-resolve while full, FIFO order.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if_push_i = 1'b1; if_pc_i = 32'h1000 + 32'(4 * i); if_pbr_i = i[0];
            step();
            chk("fill_cnt", 32'(cnt_o), 32'(i + 1));
        end
        chk("full_flag", 32'(if_full_o), 1);
        if_pc_i = 32'hDEAD;
        step();
        chk("drop_cnt", 32'(cnt_o), 8);
        if_pc_i = 32'h2000; if_pbr_i = 1'b1;
        cm_en_i = 1'b1; cm_abr_i = 1'b0;
        step();
        chk("swap_cnt", 32'(cnt_o), 8);
        chk("swap_bp_en", 32'(bp_en_o), 1);
        chk("swap_tpc", bp_tpc_o, 32'h1000);
        chk("swap_mp", 32'(mp_o), 0);
        if_push_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cm_abr_i = (k == 8) ? 1'b1 : k[0];
            step();
            chk("order_tpc", bp_tpc_o, (k == 8) ? 32'h2000 : 32'h1000 + 32'(4 * k));
            chk("order_mp", 32'(mp_o), 0);
        end
        cm_en_i = 1'b0;
        step();
        chk("drain_cnt", 32'(cnt_o), 0);
        chk("drain_full", 32'(if_full_o), 0);

        // en low freezes state and suppresses strobes.
        if_push_i = 1'b1; if_pc_i = 32'h300; if_pbr_i = 1'b0;
        step();
        en = 1'b0; cm_en_i = 1'b1; cm_abr_i = 1'b1; if_pc_i = 32'h304;
        step();
        chk("hold_cnt", 32'(cnt_o), 1);
        chk("hold_mp", 32'(mp_o), 0);
        chk("hold_bp_en", 32'(bp_en_o), 0);
        idle_inputs();

        // Sticky err, then asynchronous reset mid-cycle.
        do_reset();
        cm_en_i = 1'b1;
        step();
        chk("empty_err", 32'(err_o), 1);
        chk("empty_bp_en", 32'(bp_en_o), 0);
        chk("empty_mp", 32'(mp_o), 0);
        cm_en_i = 1'b0;
        repeat (3) step();
        chk("err_sticky", 32'(err_o), 1);
        if_push_i = 1'b1; if_pc_i = 32'h40; if_pbr_i = 1'b0;
        step();
        if_push_i = 1'b0; cm_en_i = 1'b1; cm_abr_i = 1'b1; cm_tgt_i = 32'h80;
        step();
        chk("pre_mp_pc", mp_pc_o, 32'h80);
        cm_en_i = 1'b0; if_push_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if_pc_i = 32'h500 + 32'(4 * i);
            step();
        end
        if_push_i = 1'b0;
        chk("pre_rst_cnt", 32'(cnt_o), 5);
        #2 rst = 1'b1;
        #1;
        chk("arst_cnt", 32'(cnt_o), 0);
        chk("arst_err", 32'(err_o), 0);
        chk("arst_mpcnt", 32'(mp_cnt_o), 0);
        chk("arst_tpc", bp_tpc_o, 0);
        chk("arst_mppc", mp_pc_o, 0);
        chk("arst_abr_bpen_mp", {29'd0, bp_abr_o, bp_en_o, mp_o}, 0);

        // Randomized run against a queue-based reference.
        do_reset();
        begin
            int          exp_mpcnt = 0;
            logic        exp_err   = 1'b0;
            logic        exp_bp_en, exp_mp, exp_abr;
            logic [31:0] exp_tpc, exp_mppc;
            ent_t        h;
            for (int c = 0; c < 600; c++) begin
                en        = ($urandom_range(0, 9) != 0);
                if_push_i = ($urandom_range(0, 9) < 6);
                if_pc_i   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                if_pbr_i  = $urandom_range(0, 1);
                cm_en_i   = ($urandom_range(0, 9) < 5);
                cm_abr_i  = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
                cm_tgt_i  = $urandom;
                exp_bp_en = 1'b0; exp_mp = 1'b0; exp_abr = 1'b0;
                exp_tpc = '0; exp_mppc = '0;
                if (en) begin
                    if (cm_en_i && mq.size() == 0) exp_err = 1'b1;
                    if (cm_en_i && mq.size() > 0) begin
                        h = mq.pop_front();
                        exp_bp_en = 1'b1; exp_abr = cm_abr_i; exp_tpc = h.pc;
                        if (h.pbr != cm_abr_i) begin
                            exp_mp = 1'b1;
                            exp_mppc = cm_abr_i ? cm_tgt_i : h.pc + 32'd4;
                            if (exp_mpcnt < 65535) exp_mpcnt++;
                            mq.delete();
                        end
                    end
                    if (if_push_i && !exp_mp && mq.size() < DEPTH)
                        mq.push_back('{if_pc_i, if_pbr_i});
                end
                step();
                chk("r_bp_en", 32'(bp_en_o), 32'(exp_bp_en));
                chk("r_mp", 32'(mp_o), 32'(exp_mp));
                chk("r_cnt", 32'(cnt_o), 32'(mq.size()));
                chk("r_full", 32'(if_full_o), 32'(mq.size() == DEPTH));
                chk("r_err", 32'(err_o), 32'(exp_err));
                chk("r_mpcnt", 32'(mp_cnt_o), 32'(exp_mpcnt));
                if (exp_bp_en) begin
                    chk("r_abr", 32'(bp_abr_o), 32'(exp_abr));
                    chk("r_tpc", bp_tpc_o, exp_tpc);
                end
                if (exp_mp) chk("r_mppc", mp_pc_o, exp_mppc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
